multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, one shared instruction/data memory port and the immediate generator across fetch, decode, execute, memory and writeback cycles. It drives the immediate generator's 3-bit ImmSrc select (000=I, 001=S, 010=B, 011=J, 100=U) from the latched opcode. It also stalls on a memory ready handshake.

Parameters:
OP_WIDTH, 7, opcode field width (fixed by ISA; not for override)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active low
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
zero  input  1  ALU zero flag, combinational from current ALU operation
mem_ready  input  1  memory access completes this cycle
ImmSrc  output  3  immediate generator select
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=const 4
ALUOp  output  2  00=add, 01=subtract/compare, 10=decode by funct
ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALUResult, 11=ImmExt
AdrSrc  output  1  memory address: 0=PC, 1=Result
IRWrite  output  1  load instruction register and OldPC
PCWrite  output  1  load PC from Result
RegWrite  output  1  register file write enable
MemWrite  output  1  data memory write request
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Clock is clk. Reset is synchronous and active low on rst_n. When rst_n=0 at a rising edge, state becomes FETCH.
- While rst_n=0, every enable and pulse output is 0: IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_op. All selects are 0.
- Reset asserted mid-instruction aborts the instruction. No enable is asserted in the reset cycle.
- Outputs are combinational from state, op, funct3, zero and mem_ready (Moore outputs plus the listed gated terms). Signals not listed for a state are 0.
- ImmSrc is decoded from op in every state:
  - 0000011, 0010011, 1100111 -> 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 1101111 -> 011
  - 0110111, 0010111 -> 100
  - any other op -> 000
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op:
    - lw/sw -> MEMADR; R (0110011) -> EXECR; I-ALU (0010011) -> EXECI
    - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC
    - any other op -> FETCH, with illegal_op=1 and instr_done=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Goes to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held constant while waiting. When mem_ready=1: instr_done=1, go to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Goes to FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done=1.
    - funct3=000 (beq): PCWrite=zero. funct3=001 (bne): PCWrite=~zero. Other funct3: PCWrite=0.
    - Goes to FETCH.
  - JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (rs1+imm into ALUOut). Goes to JAL.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (PC <- target; ALUOut <- OldPC+4). Goes to ALUWB.
    - The jalr target bit 0 is not cleared by this block.
  - LUI: ResultSrc=11, RegWrite=1, instr_done=1. Goes to FETCH.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Goes to ALUWB.
- Latency in cycles with mem_ready constantly 1: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3, auipc 4, illegal 2. Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- At most one of RegWrite and MemWrite is 1 in any cycle. IRWrite is 1 only in FETCH.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles during MEMWRITE -> all enables 0 in those cycles; on release the state is FETCH, and IRWrite=1 when mem_ready=1.
- add x3,x1,x2 (op=0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4; instr_done pulses once.
- lw (0000011) with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMREAD -> 10 cycles total. ImmSrc=000 from DECODE on; RegWrite with ResultSrc=01 only in the last cycle.
- sw (0100011) -> ImmSrc=001. MemWrite=1, AdrSrc=1 held through a 2-cycle mem_ready stall; never RegWrite.
- beq/bne (1100011) -> ImmSrc=010.
  - beq with zero=1 -> PCWrite=1 in the BRANCH cycle.
  - bne with zero=1 -> PCWrite=0.
  - funct3=100 -> PCWrite=0.
- jal, jalr, lui, op=0000000:
  - jal -> ImmSrc=011, PCWrite in JAL, RegWrite in ALUWB, 4 cycles.
  - jalr -> JALR then JAL, 5 cycles.
  - lui -> ImmSrc=100, ResultSrc=11, 3 cycles.
  - op=0000000 -> illegal_op=1 in DECODE, back to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU,
// the single memory port and the immediate generator, stalling on mem_ready.
module multicycle_controller #(
  parameter int OP_WIDTH = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [2:0]          ImmSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          ResultSrc,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                instr_done,
  output logic                illegal_op
);

  localparam logic [OP_WIDTH-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_WIDTH-1:0] OP_STORE = 7'b0100011;
  localparam logic [OP_WIDTH-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_WIDTH-1:0] OP_I     = 7'b0010011;
  localparam logic [OP_WIDTH-1:0] OP_BR    = 7'b1100011;
  localparam logic [OP_WIDTH-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_WIDTH-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_WIDTH-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JALR, JAL, LUI, AUIPC
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JALR:     state_d = JAL;
      JAL:      state_d = ALUWB;
      LUI:      state_d = FETCH;
      AUIPC:    state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Everything is forced low while rst_n is held, whatever the state register holds.
  always_comb begin
    ImmSrc     = 3'b000;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (op)
        OP_STORE:         ImmSrc = 3'b001;
        OP_BR:            ImmSrc = 3'b010;
        OP_JAL:           ImmSrc = 3'b011;
        OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
        default:          ImmSrc = 3'b000;
      endcase
      case (state_q)
        FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_op = 1'b0;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        MEMREAD:  AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUOp      = 2'b01;
          instr_done = 1'b1;
          case (funct3)
            3'b000:  PCWrite = zero;
            3'b001:  PCWrite = ~zero;
            default: PCWrite = 1'b0;
          endcase
        end
        JALR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        // Target already sits in ALUOut; the ALU meanwhile forms the link value.
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        LUI: begin
          ResultSrc  = 2'b11;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each driven cycle queues its expected control word, and
// each instruction queues its expected latency for the instr_done monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_op;

  int checks = 0;
  int errors = 0;
  int vec_idx = 0;
  int lat_cnt = 0;
  logic [17:0] exp_q[$];
  int          lat_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] e(input logic [2:0] imm, input logic [1:0] a, b, aop, res,
                                    input logic adr, ir, pc, rw, mw, dn, il);
    return {imm, a, b, aop, res, adr, ir, pc, rw, mw, dn, il};
  endfunction

  task automatic step(input logic rn, input logic mr, input logic z, input logic [17:0] ex);
    rst_n = rn;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  // Control-word monitor: compares every cycle that has an expectation queued.
  always @(negedge clk) begin
    logic [17:0] got, ex;
    if (exp_q.size() > 0) begin
      got = {ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, AdrSrc, IRWrite,
             PCWrite, RegWrite, MemWrite, instr_done, illegal_op};
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL ctl[%0d] op=%b: got %b expected %b", vec_idx, op, got, ex);
      end else
        $display("ok   ctl[%0d] op=%b word=%b", vec_idx, op, got);
      vec_idx++;
    end
  end

  // Latency monitor: counts cycles since the last completed instruction.
  always @(negedge clk) begin
    if (!rst_n) lat_cnt = 0;
    else begin
      lat_cnt++;
      if (instr_done) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL latency: unexpected instr_done after %0d cycles", lat_cnt);
        end else begin
          int want;
          want = lat_q.pop_front();
          if (lat_cnt != want) begin
            errors++;
            $display("FAIL latency op=%b: got %0d cycles expected %0d", op, lat_cnt, want);
          end else
            $display("ok   latency op=%b: %0d cycles", op, lat_cnt);
        end
        lat_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 7'b0100011; funct3 = 3'b000;
    @(posedge clk); #1;
    // Reset: everything zero, including ImmSrc for a store opcode.
    step(0, 1, 0, 18'd0);
    step(0, 1, 0, 18'd0);

    // add x3,x1,x2
    op = 7'b0110011; lat_q.push_back(4);
    step(1, 1, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0));

    // lw with 2 fetch stalls and 3 read stalls: 10 cycles
    op = 7'b0000011; lat_q.push_back(10);
    step(1, 0, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, e(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 1, 0));

    // sw with a 2-cycle write stall
    op = 7'b0100011; lat_q.push_back(6);
    step(1, 1, 0, e(3'b001, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, e(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0));
    step(1, 0, 0, e(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0));

    // Branches: {funct3, zero, expected PCWrite}
    op = 7'b1100011;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] f3_tab [5];
      logic       z_tab  [5];
      logic       pc_tab [5];
      f3_tab = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b100};
      z_tab  = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
      pc_tab = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
      funct3 = f3_tab[i]; lat_q.push_back(3);
      step(1, 1, z_tab[i], e(3'b010, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
      step(1, 1, z_tab[i], e(3'b010, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      step(1, 1, z_tab[i], e(3'b010, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0, pc_tab[i], 0, 0, 1, 0));
    end
    funct3 = 3'b000;

    // jal
    op = 7'b1101111; lat_q.push_back(4);
    step(1, 1, 0, e(3'b011, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b011, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b011, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b011, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0));

    // jalr
    op = 7'b1100111; lat_q.push_back(5);
    step(1, 1, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0));

    // lui
    op = 7'b0110111; lat_q.push_back(3);
    step(1, 1, 0, e(3'b100, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b100, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b100, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 1, 0, 1, 0));

    // auipc
    op = 7'b0010111; lat_q.push_back(4);
    step(1, 1, 0, e(3'b100, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b100, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b100, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0));

    // addi
    op = 7'b0010011; lat_q.push_back(4);
    step(1, 1, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0));

    // illegal opcode
    op = 7'b0000000; lat_q.push_back(2);
    step(1, 1, 0, e(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1));

    // sw aborted by a 3-cycle reset while stalled in MEMWRITE, then rerun
    op = 7'b0100011;
    step(1, 1, 0, e(3'b001, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, e(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 18'd0);
    lat_q.push_back(4);
    step(1, 1, 0, e(3'b001, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, e(3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0));

    // Idle in FETCH with no memory response; no instruction may complete.
    step(1, 0, 0, e(3'b001, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ctl_drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (lat_q.size() != 0) begin
      errors++;
      $display("FAIL done_drain: got %0d instructions without instr_done expected 0", lat_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
